// File: rtl/reader_core.sv
// reader_core: fetches 16-bit instruction words over a req/ack port.
// It decodes and executes each word on a NUM_REGS x DATA_W register file.
// Each instruction goes FETCH (request/ack) -> EXEC (one cycle) -> FETCH.
// HALT freezes the whole core until reset.
module reader_core #(
  parameter int DATA_W   = 16,
  parameter int NUM_REGS = 4,
  parameter int IP_W     = 8,
  parameter int RESET_IP = 0,
  parameter int CNT_W    = 16
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        run,
  output logic                        imem_req,
  output logic [IP_W-1:0]             imem_addr,
  input  logic                        imem_ack,
  input  logic [15:0]                 imem_data,
  output logic [IP_W-1:0]             iPointer,
  output logic [3:0]                  opCode,
  input  logic [$clog2(NUM_REGS)-1:0] dbg_sel,
  output logic [DATA_W-1:0]           dbg_data,
  output logic [CNT_W-1:0]            instr_cnt,
  output logic                        halted,
  output logic                        illegal
);

  localparam int REG_AW = $clog2(NUM_REGS);

  localparam logic [3:0] OP_NOP  = 4'h0;
  localparam logic [3:0] OP_LDI  = 4'h1;
  localparam logic [3:0] OP_MOV  = 4'h2;
  localparam logic [3:0] OP_ADD  = 4'h3;
  localparam logic [3:0] OP_SUB  = 4'h4;
  localparam logic [3:0] OP_JMP  = 4'h5;
  localparam logic [3:0] OP_JZ   = 4'h6;
  localparam logic [3:0] OP_DEC  = 4'h7;
  localparam logic [3:0] OP_HALT = 4'hF;

  typedef enum logic [1:0] {
    S_FETCH = 2'd0,
    S_EXEC  = 2'd1,
    S_HALT  = 2'd2
  } state_t;

  // Architectural and control state
  state_t              r_state;
  logic                r_req;
  logic [15:0]         r_ir;
  logic [3:0]          r_op;
  logic [IP_W-1:0]     r_ip;
  logic [CNT_W-1:0]    r_cnt;
  logic                r_halted;
  logic                r_illegal;
  logic [DATA_W-1:0]   r_regs [NUM_REGS];

  // Decode fields of the latched instruction word
  logic [3:0]               w_op;
  logic [REG_AW-1:0]        w_rd;
  logic [REG_AW-1:0]        w_rs;
  logic [7:0]               w_imm;
  logic signed [DATA_W-1:0] w_rd_val;
  logic signed [DATA_W-1:0] w_rs_val;

  // Execute results, consumed on the EXEC edge
  logic                     w_wr_en;
  logic signed [DATA_W-1:0] w_wr_val;
  logic [IP_W-1:0]          w_next_ip;
  logic                     w_undef;

  // Fields wider than the configured register/ip space are intentionally dropped
  logic                     w_unused_ir;

  // Retired-instruction counter sticks at all-ones instead of wrapping
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    if (&v) begin
      return v;
    end
    return v + CNT_W'(1);
  endfunction

  assign w_op        = r_ir[15:12];
  assign w_rd        = r_ir[8 +: REG_AW];
  assign w_rs        = r_ir[4 +: REG_AW];
  assign w_imm       = r_ir[7:0];
  assign w_rd_val    = $signed(r_regs[w_rd]);
  assign w_rs_val    = $signed(r_regs[w_rs]);
  assign w_unused_ir = ^r_ir;

  // Operation decode: result value, write enable and next ip for the EXEC edge
  always_comb begin
    w_wr_en   = 1'b0;
    w_wr_val  = w_rd_val;
    w_next_ip = r_ip + IP_W'(1);
    w_undef   = 1'b0;
    case (w_op)
      OP_NOP: begin
        w_wr_en = 1'b0;
      end
      OP_LDI: begin
        w_wr_en  = 1'b1;
        w_wr_val = $signed(DATA_W'(w_imm));
      end
      OP_MOV: begin
        w_wr_en  = 1'b1;
        w_wr_val = w_rs_val;
      end
      OP_ADD: begin
        w_wr_en  = 1'b1;
        w_wr_val = w_rd_val + w_rs_val;
      end
      OP_SUB: begin
        w_wr_en  = 1'b1;
        w_wr_val = w_rd_val - w_rs_val;
      end
      OP_JMP: begin
        w_next_ip = w_imm[IP_W-1:0];
      end
      OP_JZ: begin
        if (w_rd_val == '0) begin
          w_next_ip = w_imm[IP_W-1:0];
        end
      end
      OP_DEC: begin
        w_wr_en  = 1'b1;
        w_wr_val = w_rd_val - $signed(DATA_W'(1));
      end
      OP_HALT: begin
        w_next_ip = r_ip;
      end
      default: begin
        w_undef = 1'b1;
      end
    endcase
  end

  // Control FSM, fetch handshake, register file and status, all in one block
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state   <= S_FETCH;
      r_req     <= 1'b0;
      r_ir      <= '0;
      r_op      <= '0;
      r_ip      <= IP_W'(RESET_IP);
      r_cnt     <= '0;
      r_halted  <= 1'b0;
      r_illegal <= 1'b0;
      for (int i = 0; i < NUM_REGS; i++) begin
        r_regs[i] <= '0;
      end
    end else begin
      case (r_state)
        S_FETCH: begin
          if (!r_req) begin
            // run only gates the start of a fetch; an ack here is stale
            if (run) begin
              r_req <= 1'b1;
            end
          end else if (imem_ack) begin
            r_ir    <= imem_data;
            r_op    <= imem_data[15:12];
            r_req   <= 1'b0;
            r_state <= S_EXEC;
          end
        end
        S_EXEC: begin
          if (w_wr_en) begin
            r_regs[w_rd] <= w_wr_val;
          end
          r_ip  <= w_next_ip;
          r_cnt <= sat_inc(r_cnt);
          if (w_undef) begin
            r_illegal <= 1'b1;
          end
          if (w_op == OP_HALT) begin
            r_halted <= 1'b1;
            r_state  <= S_HALT;
          end else begin
            r_state <= S_FETCH;
          end
        end
        S_HALT: begin
          r_state <= S_HALT;
        end
        default: begin
          r_state <= S_FETCH;
        end
      endcase
    end
  end

  assign imem_req  = r_req;
  assign imem_addr = r_ip;
  assign iPointer  = r_ip;
  assign opCode    = r_op;
  assign dbg_data  = r_regs[dbg_sel];
  assign instr_cnt = r_cnt;
  assign halted    = r_halted;
  assign illegal   = r_illegal;

endmodule

// File: tb/tb_reader_core.sv
// Bench for reader_core: three configurations (default, DATA_W=8, 16 regs with 2-bit counter).
// Results are compared against an instruction-level interpreter of the ISA.
module tb_reader_core;

  logic        clk   = 1'b0;
  logic        reset = 1'b0;
  logic [15:0] prog [256];
  logic [3:0]  dsel  = '0;

  // Instance A: default parameters, ack/run driven by the bench
  logic        a_run = 1'b0, a_ack = 1'b0, a_req, a_halted, a_illegal;
  logic [7:0]  a_addr, a_ip;
  logic [3:0]  a_op;
  logic [15:0] a_dbg, a_cnt, a_data;
  // Instance B: DATA_W = 8, ack tied high
  logic        b_run = 1'b0, b_req, b_halted, b_illegal;
  logic [7:0]  b_addr, b_ip, b_dbg;
  logic [3:0]  b_op;
  logic [15:0] b_cnt, b_data;
  // Instance C: NUM_REGS = 16, CNT_W = 2, ack tied high
  logic        c_run = 1'b0, c_req, c_halted, c_illegal;
  logic [7:0]  c_addr, c_ip;
  logic [3:0]  c_op;
  logic [1:0]  c_cnt;
  logic [15:0] c_dbg, c_data;

  assign a_data = prog[a_addr];
  assign b_data = prog[b_addr];
  assign c_data = prog[c_addr];

  reader_core u_a (
    .clk(clk), .reset(reset), .run(a_run), .imem_req(a_req), .imem_addr(a_addr),
    .imem_ack(a_ack), .imem_data(a_data), .iPointer(a_ip), .opCode(a_op),
    .dbg_sel(dsel[1:0]), .dbg_data(a_dbg), .instr_cnt(a_cnt), .halted(a_halted),
    .illegal(a_illegal)
  );

  reader_core #(.DATA_W(8)) u_b (
    .clk(clk), .reset(reset), .run(b_run), .imem_req(b_req), .imem_addr(b_addr),
    .imem_ack(1'b1), .imem_data(b_data), .iPointer(b_ip), .opCode(b_op),
    .dbg_sel(dsel[1:0]), .dbg_data(b_dbg), .instr_cnt(b_cnt), .halted(b_halted),
    .illegal(b_illegal)
  );

  reader_core #(.NUM_REGS(16), .CNT_W(2)) u_c (
    .clk(clk), .reset(reset), .run(c_run), .imem_req(c_req), .imem_addr(c_addr),
    .imem_ack(1'b1), .imem_data(c_data), .iPointer(c_ip), .opCode(c_op),
    .dbg_sel(dsel), .dbg_data(c_dbg), .instr_cnt(c_cnt), .halted(c_halted),
    .illegal(c_illegal)
  );

  always #5 clk = ~clk;

  int n_total = 0;
  int n_bad   = 0;

  task automatic check_val(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  // Memory side of instance A: 0 = ack tied high, 1 = random 0..5 cycle delay, 2 = never ack
  int   a_mode     = 0;
  int   a_wait     = 0;
  int   a_delay    = 0;
  bit   a_run_en   = 1'b0;
  bit   a_run_rand = 1'b0;
  bit   mon_en     = 1'b0;
  logic p_req      = 1'b0;
  logic p_ack      = 1'b0;

  always @(negedge clk) begin
    if (mon_en && !reset && p_req && !p_ack) begin
      check_val("req_hold", 32'(a_req), 32'd1);
    end
    if (!a_req) begin
      a_wait  = 0;
      a_delay = int'($urandom_range(0, 5));
    end
    case (a_mode)
      0:       a_ack = 1'b1;
      1:       a_ack = a_req ? (a_wait >= a_delay) : 1'($urandom_range(0, 1));
      default: a_ack = 1'b0;
    endcase
    if (a_req) a_wait++;
    a_run = a_run_rand ? 1'($urandom_range(0, 1)) : a_run_en;
    p_req = a_req;
    p_ack = a_ack;
  end

  // what: 0 halted, 1 ip, 2 cnt, 3 illegal, 4 dbg, 5 req, 6 opcode
  function automatic logic [31:0] probe(input int which, input int what);
    case (which)
      0: case (what)
        0: return 32'(a_halted);  1: return 32'(a_ip);  2: return 32'(a_cnt);
        3: return 32'(a_illegal); 4: return 32'(a_dbg); 5: return 32'(a_req);
        default: return 32'(a_op);
      endcase
      1: case (what)
        0: return 32'(b_halted);  1: return 32'(b_ip);  2: return 32'(b_cnt);
        3: return 32'(b_illegal); 4: return 32'(b_dbg); 5: return 32'(b_req);
        default: return 32'(b_op);
      endcase
      default: case (what)
        0: return 32'(c_halted);  1: return 32'(c_ip);  2: return 32'(c_cnt);
        3: return 32'(c_illegal); 4: return 32'(c_dbg); 5: return 32'(c_req);
        default: return 32'(c_op);
      endcase
    endcase
  endfunction

  // Instruction-level interpreter of the ISA
  int m_regs [16];
  int m_ip, m_cnt, m_halt, m_ill;

  task automatic ref_run(input int dw, input int nr, input int cw);
    int          dm, op, rd, rs, imm, nip;
    logic [15:0] w;
    dm = (1 << dw) - 1;
    foreach (m_regs[i]) m_regs[i] = 0;
    m_ip = 0; m_cnt = 0; m_halt = 0; m_ill = 0;
    for (int s = 0; s < 5000 && m_halt == 0; s++) begin
      w   = prog[m_ip];
      op  = int'(w[15:12]);
      rd  = int'(w[11:8]) % nr;
      rs  = int'(w[7:4]) % nr;
      imm = int'(w[7:0]);
      nip = (m_ip + 1) % 256;
      case (op)
        1:  m_regs[rd] = imm & dm;
        2:  m_regs[rd] = m_regs[rs];
        3:  m_regs[rd] = (m_regs[rd] + m_regs[rs]) & dm;
        4:  m_regs[rd] = (m_regs[rd] - m_regs[rs]) & dm;
        5:  nip = imm;
        6:  if (m_regs[rd] == 0) nip = imm;
        7:  m_regs[rd] = (m_regs[rd] - 1) & dm;
        15: begin m_halt = 1; nip = m_ip; end
        8, 9, 10, 11, 12, 13, 14: m_ill = 1;
        default: ;
      endcase
      if (m_cnt < (1 << cw) - 1) m_cnt++;
      m_ip = nip;
    end
  endtask

  task automatic compare_model(input int which, input string tag);
    int dw, nr, cw;
    dw = (which == 1) ? 8 : 16;
    nr = (which == 2) ? 16 : 4;
    cw = (which == 2) ? 2 : 16;
    ref_run(dw, nr, cw);
    check_val({tag, ":halted"},  probe(which, 0), 32'(m_halt));
    check_val({tag, ":ip"},      probe(which, 1), 32'(m_ip));
    check_val({tag, ":cnt"},     probe(which, 2), 32'(m_cnt));
    check_val({tag, ":illegal"}, probe(which, 3), 32'(m_ill));
    for (int r = 0; r < nr; r++) begin
      dsel = 4'(r);
      #1;
      check_val($sformatf("%s:r%0d", tag, r), probe(which, 4), 32'(m_regs[r]));
    end
  endtask

  task automatic start(input int which);
    reset    = 1'b1;
    a_run_en = (which == 0);
    b_run    = (which == 1);
    c_run    = (which == 2);
    dsel     = '0;
    repeat (2) @(negedge clk);
    #2 reset = 1'b0;
  endtask

  task automatic wait_halt(input int which, input int budget, output int cyc);
    cyc = 0;
    while (probe(which, 0) == 0 && cyc < budget) begin
      @(posedge clk);
      #1;
      cyc++;
    end
  endtask

  task automatic clear_prog();
    for (int i = 0; i < 256; i++) prog[i] = 16'hF000;
  endtask

  task automatic load_add_prog();
    clear_prog();
    prog[0] = 16'h1005; prog[1] = 16'h1103; prog[2] = 16'h3010; prog[3] = 16'hF000;
  endtask

  task automatic gen_random();
    int len, op, imm;
    clear_prog();
    len = int'($urandom_range(4, 20));
    for (int i = 0; i < len; i++) begin
      op  = int'($urandom_range(0, 14));
      imm = (op == 5 || op == 6) ? int'($urandom_range(i + 1, len)) : int'($urandom_range(0, 255));
      prog[i] = {4'(op), 4'($urandom_range(0, 15)), 8'(imm)};
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int cyc;

    // Reset asserted in the middle of a pending fetch
    clear_prog();
    a_mode = 2;
    start(0);
    for (int i = 0; i < 20 && !a_req; i++) begin
      @(posedge clk);
      #1;
    end
    check_val("t1_req_up", 32'(a_req), 32'd1);
    @(negedge clk);
    #1 reset = 1'b1;
    #1;
    check_val("t1_rst_req", probe(0, 5), 32'd0);
    check_val("t1_rst_ip",  probe(0, 1), 32'd0);
    check_val("t1_rst_cnt", probe(0, 2), 32'd0);
    check_val("t1_rst_op",  probe(0, 6), 32'd0);
    check_val("t1_rst_hlt", probe(0, 0), 32'd0);
    @(negedge clk);
    #2 reset = 1'b0;
    #1;
    check_val("t1_rel_req", probe(0, 5), 32'd0);
    @(posedge clk);
    #1;
    check_val("t1_req_again", probe(0, 5), 32'd1);

    // LDI/LDI/ADD/HALT with ack tied high: 3 cycles per instruction
    load_add_prog();
    a_mode = 0;
    start(0);
    wait_halt(0, 200, cyc);
    check_val("t2_cycles", 32'(cyc), 32'd12);
    check_val("t2_cnt", probe(0, 2), 32'd4);
    check_val("t2_ip",  probe(0, 1), 32'd3);
    dsel = 4'd0; #1 check_val("t2_r0", probe(0, 4), 32'd8);
    dsel = 4'd1; #1 check_val("t2_r1", probe(0, 4), 32'd3);
    compare_model(0, "t2");
    repeat (6) @(posedge clk);
    #1;
    check_val("t2_frozen_req", probe(0, 5), 32'd0);
    check_val("t2_frozen_cnt", probe(0, 2), 32'd4);
    check_val("t2_frozen_ip",  probe(0, 1), 32'd3);

    // Countdown loop with JZ/JMP
    clear_prog();
    prog[0] = 16'h1103; prog[1] = 16'h7100; prog[2] = 16'h6104;
    prog[3] = 16'h5001; prog[4] = 16'hF000;
    start(0);
    wait_halt(0, 400, cyc);
    check_val("t3_cnt", probe(0, 2), 32'd10);
    check_val("t3_ip",  probe(0, 1), 32'd4);
    dsel = 4'd1; #1 check_val("t3_r1", probe(0, 4), 32'd0);
    compare_model(0, "t3");

    // Random ack latency with run toggling during requests
    load_add_prog();
    a_mode = 1; a_run_rand = 1'b1; mon_en = 1'b1;
    start(0);
    wait_halt(0, 2000, cyc);
    mon_en = 1'b0; a_run_rand = 1'b0;
    check_val("t4_cnt", probe(0, 2), 32'd4);
    dsel = 4'd0; #1 check_val("t4_r0", probe(0, 4), 32'd8);
    compare_model(0, "t4");

    // 8-bit data: DEC wraps to FF, undefined opcode, ip wrap FF -> 00
    clear_prog();
    prog[8'h00] = 16'h6110; prog[8'h01] = 16'hF000;
    prog[8'h10] = 16'h1000; prog[8'h11] = 16'h1101; prog[8'h12] = 16'h7000;
    prog[8'h13] = 16'h9000; prog[8'h14] = 16'h50FF; prog[8'hFF] = 16'h0000;
    start(1);
    wait_halt(1, 400, cyc);
    dsel = 4'd0; #1 check_val("t5_r0", probe(1, 4), 32'hFF);
    check_val("t5_illegal", probe(1, 3), 32'd1);
    check_val("t5_ip",      probe(1, 1), 32'd1);
    check_val("t5_cnt",     probe(1, 2), 32'd9);
    compare_model(1, "t5");

    // 16 registers, 2-bit saturating counter
    clear_prog();
    prog[0] = 16'h10AA; prog[1] = 16'h2F00; prog[2] = 16'h0000; prog[3] = 16'h0000;
    start(2);
    wait_halt(2, 400, cyc);
    dsel = 4'd15; #1 check_val("t6_r15", probe(2, 4), 32'hAA);
    check_val("t6_cnt", probe(2, 2), 32'd3);
    compare_model(2, "t6");

    // Random programs on every configuration
    for (int it = 0; it < 12; it++) begin
      int which;
      which = it % 3;
      gen_random();
      if (which == 0) begin
        a_mode = 1; a_run_rand = 1'b1; mon_en = 1'b1;
      end
      start(which);
      wait_halt(which, 3000, cyc);
      mon_en = 1'b0; a_run_rand = 1'b0; a_mode = 0;
      compare_model(which, $sformatf("rnd%0d", it));
    end

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
